// File: rtl/vector_addsub_n_tm.sv
// vector_addsub_n_tm
//   Element-wise signed add/subtract of two NUM_ELEM-element vectors,
//   computed LANES elements per clock over BEATS = NUM_ELEM/LANES beats.
//   Each element result is one bit wider than the operands, so it never
//   overflows.
//
//   Ports
//     clk            rising-edge clock
//     reset          asynchronous active-low reset
//     enable         global clock enable; low freezes every register
//     inReady        new-vector strobe (accepted in IDLE or DONE)
//     sub            operation, captured with the operands: 0 add, 1 subtract
//     A, B           flattened signed operands, element i at [i*IN_WIDTH +: IN_WIDTH]
//     S              flattened signed result, element i at [i*(IN_WIDTH+1) +: IN_WIDTH+1]
//     outReady       S holds a complete result (DONE state)
//     earlyOutReady  last RUN beat, one enabled cycle ahead of outReady
//     busy           a vector is in flight (RUN state)
//     overrun        sticky: a different vector was offered while in RUN
//
//   NUM_ELEM must be a multiple of LANES and LANES >= 1.

// One add/sub unit: sign-extends both operands by one bit, then adds or
// subtracts.
module vector_addsub_lane #(
  parameter int IN_WIDTH = 10
) (
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  input  logic                sub,
  output logic [IN_WIDTH:0]   s
);
  logic signed [IN_WIDTH:0] ax, bx;

  assign ax = {a[IN_WIDTH-1], a};
  assign bx = {b[IN_WIDTH-1], b};
  assign s  = sub ? (ax - bx) : (ax + bx);
endmodule

module vector_addsub_n_tm #(
  parameter int IN_WIDTH = 10,
  parameter int NUM_ELEM = 4,
  parameter int LANES    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             inReady,
  input  logic                             sub,
  input  logic [NUM_ELEM*IN_WIDTH-1:0]     A,
  input  logic [NUM_ELEM*IN_WIDTH-1:0]     B,
  output logic [NUM_ELEM*(IN_WIDTH+1)-1:0] S,
  output logic                             outReady,
  output logic                             earlyOutReady,
  output logic                             busy,
  output logic                             overrun
);
  localparam int BEATS = NUM_ELEM / LANES;
  localparam int OW    = IN_WIDTH + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operand/result storage is [beat][lane][bits]; this packs element
  // beat*LANES+lane at the same bit offset as the flat ports, so the flat
  // buses can be assigned directly.
  state_t                                  state_q, state_d;
  logic [BW-1:0]                           beat_q, beat_d;
  logic [BEATS-1:0][LANES-1:0][IN_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                                    sub_q, sub_d;
  logic [BEATS-1:0][LANES-1:0][OW-1:0]     s_q, s_d;
  logic                                    ovr_q, ovr_d;
  logic [LANES-1:0][OW-1:0]                lane_s;
  logic                                    same_vec;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    vector_addsub_lane #(.IN_WIDTH(IN_WIDTH)) u_lane (
      .a   (a_q[beat_q][j]),
      .b   (b_q[beat_q][j]),
      .sub (sub_q),
      .s   (lane_s[j])
    );
  end

  // A strobe held high through RUN with the in-flight operands unchanged is
  // a held request (back-to-back streaming), not a lost vector.
  assign same_vec = (A == a_q) && (B == b_q) && (sub == sub_q);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    s_d     = s_q;
    ovr_d   = ovr_q;
    if (enable) begin
      case (state_q)
        RUN: begin
          for (int j = 0; j < LANES; j++) s_d[beat_q][j] = lane_s[j];
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
          if (inReady && !same_vec) ovr_d = 1'b1;
        end
        default: begin  // IDLE, DONE
          if (inReady) begin
            state_d = RUN;
            beat_d  = '0;
            a_d     = A;
            b_d     = B;
            sub_d   = sub;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      ovr_q   <= ovr_d;
    end
  end

  // Status decoded from registered state only; a disabled clock holds the
  // state, which stretches these pulses.
  assign S             = s_q;
  assign busy          = (state_q == RUN);
  assign earlyOutReady = (state_q == RUN) && (beat_q == LAST_BEAT);
  assign outReady      = (state_q == DONE);
  assign overrun       = ovr_q;
endmodule
